// File: rtl/fp_pkg.sv
// Shared definitions for the 13-bit sign-magnitude floating-point experiments:
// word geometry, signed-zero constants and the max/min scanner state encoding.
package fp_pkg;

    localparam int FP_W     = 13;
    localparam int SIGN_BIT = 12;
    localparam int MAG_W    = 12;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 13'h0000;
    localparam logic [FP_W-1:0] FP_NEG_ZERO = 13'h1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CMP_MAX = 3'd2,
        ST_CMP_MIN = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic [MAG_W-1:0] fp_mag(input logic [FP_W-1:0] x);
        return x[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/fp_gt_core.sv
// Strict greater-than for sign-magnitude words; +0 ranks above -0 and
// identical words compare as not greater.
module fp_gt_core
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic            gt
);

    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;

    assign mag_a = fp_mag(a);
    assign mag_b = fp_mag(b);

    always_comb begin
        gt = 1'b0;
        case ({a[SIGN_BIT], b[SIGN_BIT]})
            2'b00: gt = (mag_a > mag_b);
            2'b11: gt = (mag_a < mag_b);
            2'b01: gt = 1'b1;
            2'b10: gt = 1'b0;
            default: gt = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_stream_maxmin.sv
// Scans a block of streamed words and reports max/min values with their
// first-occurrence indices, using one time-shared comparator.
//
// state   | meaning
// IDLE    | waiting for start; results held
// WAIT    | din_ready high, waiting for the next word
// CMP_MAX | comparator tests cand against running max
// CMP_MIN | comparator tests running min against cand; advance or finish
// DONE    | one-cycle done_tick, empty flag updated
module fp_stream_maxmin
    import fp_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [FP_W-1:0]  din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [FP_W-1:0]  max_out,
    output logic [FP_W-1:0]  min_out,
    output logic [CNT_W-1:0] max_idx,
    output logic [CNT_W-1:0] min_idx,
    output logic             busy,
    output logic             empty,
    output logic             done_tick
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] idx;
    logic [FP_W-1:0]  cand;
    logic             zero_len;
    logic [FP_W-1:0]  cmp_a;
    logic [FP_W-1:0]  cmp_b;
    logic             cmp_gt;
    logic             last;

    assign last = (idx == (len_r - CNT_W'(1)));

    fp_gt_core u_gt (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt)
    );

    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        done_tick = 1'b0;
        busy      = (state != ST_IDLE);
        cmp_a     = FP_POS_ZERO;
        cmp_b     = FP_POS_ZERO;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = (len == '0) ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                din_ready = 1'b1;
                if (din_valid)
                    state_nxt = ST_CMP_MAX;
            end
            ST_CMP_MAX: begin
                cmp_a     = cand;
                cmp_b     = max_out;
                state_nxt = ST_CMP_MIN;
            end
            ST_CMP_MIN: begin
                cmp_a     = min_out;
                cmp_b     = cand;
                state_nxt = last ? ST_DONE : ST_WAIT;
            end
            ST_DONE: begin
                done_tick = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Index 0 always seeds both extremes, so stale results never leak in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r    <= '0;
            idx      <= '0;
            cand     <= '0;
            zero_len <= 1'b0;
            max_out  <= '0;
            min_out  <= '0;
            max_idx  <= '0;
            min_idx  <= '0;
            empty    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_r    <= len;
                        idx      <= '0;
                        zero_len <= (len == '0);
                    end
                end
                ST_WAIT: begin
                    if (din_valid)
                        cand <= din;
                end
                ST_CMP_MAX: begin
                    if (cmp_gt || idx == '0) begin
                        max_out <= cand;
                        max_idx <= idx;
                    end
                end
                ST_CMP_MIN: begin
                    if (cmp_gt || idx == '0) begin
                        min_out <= cand;
                        min_idx <= idx;
                    end
                    if (!last)
                        idx <= idx + CNT_W'(1);
                end
                ST_DONE: empty <= zero_len;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_stream_maxmin.sv
// Directed and randomized checks of fp_stream_maxmin against an ordering
// model that maps each word onto a signed integer rank.
module tb_fp_stream_maxmin;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic [12:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [12:0] max_out;
    logic [12:0] min_out;
    logic [7:0]  max_idx;
    logic [7:0]  min_idx;
    logic        busy;
    logic        empty;
    logic        done_tick;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [12:0] w [256];
    logic [12:0] prev_max, prev_min;
    logic [7:0]  prev_maxi, prev_mini;

    fp_stream_maxmin #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .din(din),
        .din_valid(din_valid), .din_ready(din_ready), .max_out(max_out),
        .min_out(min_out), .max_idx(max_idx), .min_idx(min_idx),
        .busy(busy), .empty(empty), .done_tick(done_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // +0 ranks just above -0; equal words share a rank.
    function automatic int rank(input logic [12:0] x);
        int m;
        m = int'(x[11:0]);
        return x[12] ? -(2 * m) - 1 : 2 * m;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk(tag, {max_out, min_out, max_idx, min_idx, busy, empty, done_tick, din_ready}, 32'h0);
    endtask

    // mode 0: valid held, 1: random valid, 2: valid one cycle in six
    task automatic scan(input int n, input int mode, input bit extra_start, input string tag);
        int k, t0, tdone, ndone, bad, emi, eni;
        bit v, took;
        logic [12:0] em, en;
        k = 0; ndone = 0; tdone = -1; bad = 0; took = 0;
        @(negedge clk);
        start = 1'b1; len = n[7:0]; t0 = cyc;
        for (int c = 0; c < 4000 && ndone == 0; c++) begin
            if (c > 0) begin
                @(negedge clk);
                start = extra_start && (c == 6);
            end
            if (done_tick) begin ndone++; tdone = cyc; end
            if (din_ready && (k >= n || took || !busy)) bad++;
            din = w[k < 256 ? k : 0];
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 2) != 0) : ((cyc % 6) == 0);
            din_valid = v;
            took = din_ready && v;
            if (took) k++;
        end
        start = 1'b0; din_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done_tick) ndone++;
            if (din_ready) bad++;
        end
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " consumed"}, k, n);
        chk({tag, " ready_window"}, bad, 0);
        chk({tag, " idle_after"}, busy, 0);
        if (mode == 0 && !extra_start)
            chk({tag, " latency"}, tdone - t0, 3 * n + 1);
        if (n == 0) begin
            em = prev_max; en = prev_min; emi = prev_maxi; eni = prev_mini;
        end else begin
            em = w[0]; en = w[0]; emi = 0; eni = 0;
            for (int i = 1; i < n; i++) begin
                if (rank(w[i]) > rank(em)) begin em = w[i]; emi = i; end
                if (rank(w[i]) < rank(en)) begin en = w[i]; eni = i; end
            end
        end
        chk({tag, " max_out"}, max_out, em);
        chk({tag, " max_idx"}, max_idx, emi);
        chk({tag, " min_out"}, min_out, en);
        chk({tag, " min_idx"}, min_idx, eni);
        chk({tag, " empty"}, empty, n == 0);
        prev_max = em; prev_min = en; prev_maxi = emi[7:0]; prev_mini = eni[7:0];
    endtask

    initial begin
        int t0, nd;
        reset = 1'b1; start = 1'b0; len = '0; din = '0; din_valid = 1'b0;
        prev_max = '0; prev_min = '0; prev_maxi = '0; prev_mini = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        reset = 1'b0;

        w[0] = 13'h0120; w[1] = 13'h0340; w[2] = 13'h1150;
        scan(3, 0, 1'b0, "mixed");

        w[0] = 13'h1210; w[1] = 13'h1105; w[2] = 13'h1300;
        scan(3, 0, 1'b0, "all_neg");

        w[0] = 13'h1000; w[1] = 13'h0000; w[2] = 13'h0000; w[3] = 13'h1000;
        scan(4, 0, 1'b0, "zeros_ties");

        w[0] = 13'h0455;
        scan(1, 0, 1'b0, "single");

        w[0] = 13'h0a11; w[1] = 13'h1a11;
        scan(2, 2, 1'b1, "handshake");

        scan(0, 0, 1'b0, "len0");
        w[0] = 13'h1777;
        scan(1, 0, 1'b0, "after_len0");

        // Abort during CMP_MAX of word 2, then check a clean restart.
        w[0] = 13'h0300; w[1] = 13'h0100; w[2] = 13'h0200;
        @(negedge clk);
        start = 1'b1; len = 8'd3; t0 = cyc; din_valid = 1'b1; din = w[0];
        nd = 0;
        for (int c = 0; c < 40 && cyc < t0 + 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            din = w[(cyc - t0 - 1) / 3 < 3 ? (cyc - t0 - 1) / 3 : 0];
            if (done_tick) nd++;
        end
        reset = 1'b1;
        #1;
        chk_all_zero("mid_reset_outputs");
        @(negedge clk);
        reset = 1'b0; din_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_tick) nd++;
        end
        chk("mid_reset_no_done", nd, 0);
        chk_all_zero("mid_reset_settled");
        prev_max = '0; prev_min = '0; prev_maxi = '0; prev_mini = '0;
        scan(3, 0, 1'b0, "restart");

        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    w[i] = ($urandom_range(0, 1) != 0) ? 13'h1000 : 13'h0000;
                else if ($urandom_range(0, 2) == 0)
                    w[i] = {$urandom_range(0, 1) != 0, 12'h040 + 12'($urandom_range(0, 2))};
                else
                    w[i] = 13'($urandom);
            end
            scan(n, r % 3, r % 4 == 1, "random");
        end
        scan(0, 0, 1'b0, "len0_late");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
